// File: rtl/gelato_l1_cache_arbiter.sv
// Round-robin arbiter that shares one L1 cache port among NUM_CH requesters,
// with a single outstanding read or write transaction at a time.
module gelato_l1_cache_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic                         mem_valid,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_done,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);

  localparam int PTR_W = $clog2(NUM_CH);

  // Handshake: a requester holds ch_valid (and its request fields until granted)
  // until it sees its ch_done pulse; the cache sees mem_valid held stable with
  // the latched request until it pulses mem_done once, with mem_rdata valid then.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PTR_W-1:0]        r_rr_ptr;
  logic [PTR_W-1:0]        r_grant;
  logic [PTR_W-1:0]        w_sel;
  logic                    w_sel_found;
  logic                    w_sel_we;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [PTR_W-1:0]        w_grant_nxt;
  logic [NUM_CH-1:0]       w_grant_onehot;
  logic                    r_mem_valid;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [NUM_CH-1:0]       r_ch_done;
  logic [DATA_WIDTH-1:0]   r_ch_rdata;

  // First requesting channel at or after the pointer, wrapping modulo NUM_CH.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    sum         = '0;
    idx         = '0;
    w_sel       = '0;
    w_sel_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_CH)) begin
        sum = sum - (PTR_W+1)'(NUM_CH);
      end
      idx = sum[PTR_W-1:0];
      if (!w_sel_found && ch_valid[idx]) begin
        w_sel       = idx;
        w_sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (PTR_W'(i) == w_sel) begin
        w_sel_we    = ch_we[i];
        w_sel_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_grant_nxt    = (r_grant == PTR_W'(NUM_CH-1)) ? '0 : r_grant + 1'b1;
  assign w_grant_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_sel_found) w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_done) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ch_done   <= '0;
      r_ch_rdata  <= '0;
    end else begin
      r_ch_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_found) begin
            r_grant     <= w_sel;
            r_mem_valid <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
          end
        end
        S_BUSY: begin
          if (mem_done) begin
            r_mem_valid <= 1'b0;
            r_ch_done   <= w_grant_onehot;
            r_rr_ptr    <= w_grant_nxt;
            // Writes leave the last read result visible to requesters.
            if (!r_mem_we) begin
              r_ch_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_done   = r_ch_done;
  assign ch_rdata  = r_ch_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gelato_l1_cache_arbiter.sv
// Directed and randomized bench for gelato_l1_cache_arbiter, checked against a
// transaction-level reference model of the arbitration and completion rules.
module tb_gelato_l1_cache_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      ch_valid;
  logic [N-1:0]      ch_we;
  logic [N*AW-1:0]   ch_addr;
  logic [N*DW-1:0]   ch_wdata;
  logic [N-1:0]      ch_done;
  logic [DW-1:0]     ch_rdata;
  logic              mem_valid;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_done;
  logic [DW-1:0]     mem_rdata;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the port, what it latched, what was returned.
  bit                m_active;
  bit                m_resp;
  int                m_rr;
  int                m_g;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [DW-1:0]     m_rdata;
  logic [7:0]        exp_q[$];

  gelato_l1_cache_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_valid  (ch_valid),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_done   (ch_done),
    .ch_rdata  (ch_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_active = 0;
    m_resp   = 0;
    m_rr     = 0;
    m_g      = 0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_rdata  = '0;
    exp_q.delete();
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_we",    64'(mem_we),    64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_ch_done",   64'(ch_done),   64'd0);
    chk("rst_ch_rdata",  64'(ch_rdata),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver tasks
  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    ch_valid[i]           = 1'b1;
    ch_we[i]              = we;
    ch_addr[i*AW +: AW]   = a;
    ch_wdata[i*DW +: DW]  = d;
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic model_edge();
    bit old_resp;
    int g;
    old_resp = m_resp;
    m_resp   = 0;
    if (m_active) begin
      if (mem_done) begin
        m_active = 0;
        m_resp   = 1;
        m_rr     = (m_g + 1) % N;
        if (!m_we) m_rdata = mem_rdata;
      end
    end else if (!old_resp) begin
      g = rr_pick(ch_valid, m_rr);
      if (g >= 0) begin
        m_active = 1;
        m_g      = g;
        m_we     = ch_we[g];
        m_addr   = ch_addr[g*AW +: AW];
        m_wdata  = ch_wdata[g*DW +: DW];
        exp_q.push_back(8'(g));
      end
    end
  endtask

  // Scoreboard
  task automatic check_outputs();
    logic [7:0] e;
    chk("mem_valid", 64'(mem_valid), 64'(m_active));
    chk("busy",      64'(busy),      64'(m_active || m_resp));
    chk("ch_done",   64'(ch_done),   m_resp ? (64'd1 << m_g) : 64'd0);
    chk("ch_rdata",  64'(ch_rdata),  64'(m_rdata));
    if (m_active) begin
      chk("mem_we",    64'(mem_we),    64'(m_we));
      chk("mem_addr",  64'(mem_addr),  64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    if (ch_done != '0) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 64'(ch_done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_order", 64'(ch_done), 64'd1 << e);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Acts as the cache: answers lat cycles after mem_valid rises; returns the
  // channel that completed, or -1 after a bounded wait.
  task automatic serve(input int lat, output int g);
    int n;
    int waited;
    n      = 0;
    waited = 0;
    g      = -1;
    while (g < 0 && n < 64) begin
      mem_done = mem_valid && (waited >= lat);
      if (mem_done) mem_rdata = $urandom;
      if (mem_valid) waited++;
      step();
      n++;
      mem_done = 1'b0;
      for (int i = 0; i < N; i++) if (ch_done[i]) g = i;
    end
    if (g < 0) chk("serve_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int g;
    int lat;
    int lat_cnt;
    ch_valid  = '0;
    ch_we     = '0;
    ch_addr   = '0;
    ch_wdata  = '0;
    mem_done  = 1'b0;
    mem_rdata = '0;
    do_reset();

    // Single read on channel 1
    set_req(1, 1'b0, 32'h1000, 32'h0);
    step();
    chk("rd_mem_addr", 64'(mem_addr), 64'h1000);
    chk("rd_mem_we",   64'(mem_we),   64'd0);
    step();
    step();
    step();
    mem_done  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    mem_done  = 1'b0;
    chk("rd_ch_done",  64'(ch_done),  64'h2);
    chk("rd_ch_rdata", 64'(ch_rdata), 64'hDEADBEEF);
    ch_valid[1] = 1'b0;
    step();
    chk("rd_busy_low", 64'(busy), 64'd0);

    // Write on channel 0: read data must not change
    set_req(0, 1'b1, 32'h20, 32'h55AA);
    step();
    chk("wr_mem_we",    64'(mem_we),    64'd1);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'h55AA);
    mem_done  = 1'b1;
    mem_rdata = 32'h0BADF00D;
    step();
    mem_done  = 1'b0;
    chk("wr_ch_done",     64'(ch_done),  64'h1);
    chk("wr_rdata_kept",  64'(ch_rdata), 64'hDEADBEEF);
    ch_valid[0] = 1'b0;
    ch_we[0]    = 1'b0;
    step();

    // Round-robin with all channels requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h4000 + 32'(i*4), 32'h0);
    for (int n = 0; n < 6; n++) begin
      serve(0, g);
      chk("rr_order", 64'(g), 64'(n % N));
    end
    ch_valid = '0;
    step();

    // Pointer wrap: serve channel 2, then channels 0 and 2 compete
    set_req(2, 1'b0, 32'h2222, 32'h0);
    serve(1, g);
    chk("wrap_serve2", 64'(g), 64'd2);
    ch_valid[2] = 1'b0;
    set_req(0, 1'b0, 32'h0A00, 32'h0);
    set_req(2, 1'b1, 32'h0A02, 32'h1234);
    serve(2, g);
    chk("wrap_first_ch0", 64'(g), 64'd0);
    ch_valid[0] = 1'b0;
    serve(2, g);
    chk("wrap_then_ch2", 64'(g), 64'd2);
    ch_valid[2] = 1'b0;
    ch_we[2]    = 1'b0;
    step();

    // Stray mem_done while idle
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("stray_idle_done", 64'(ch_done), 64'd0);
    chk("stray_idle_busy", 64'(busy),    64'd0);

    // Channel 2 drops before its grant; stray mem_done during the response cycle
    set_req(1, 1'b0, 32'h1111, 32'h0);
    set_req(2, 1'b1, 32'h2222, 32'h77);
    step();
    chk("drop_grant_ch1", 64'(mem_addr), 64'h1111);
    ch_valid[2] = 1'b0;
    mem_done    = 1'b1;
    mem_rdata   = 32'hCAFEF00D;
    step();
    chk("drop_ch1_done", 64'(ch_done), 64'h2);
    ch_valid[1] = 1'b0;
    mem_done    = 1'b1;
    step();
    mem_done    = 1'b0;
    chk("stray_resp_done", 64'(ch_done), 64'd0);
    chk("stray_resp_busy", 64'(busy),    64'd0);
    step();
    step();
    chk("dropped_never_granted", 64'(mem_valid), 64'd0);
    ch_we[2] = 1'b0;

    // Reset in the middle of a transaction
    set_req(2, 1'b0, 32'h3333, 32'h0);
    step();
    chk("mid_busy_valid", 64'(mem_valid), 64'd1);
    ch_valid = '0;
    do_reset();
    set_req(0, 1'b0, 32'h4444, 32'h0);
    step();
    chk("post_reset_addr", 64'(mem_addr), 64'h4444);
    serve(1, g);
    chk("post_reset_ch0", 64'(g), 64'd0);
    ch_valid[0] = 1'b0;
    step();

    // Randomized traffic
    lat     = 0;
    lat_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!ch_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if (ch_valid[i] && $urandom_range(0, 7) == 0) begin
          ch_we[i]             = 1'($urandom_range(0, 1));
          ch_addr[i*AW +: AW]  = $urandom;
          ch_wdata[i*DW +: DW] = $urandom;
        end
      end
      if (mem_valid) begin
        mem_done = (lat_cnt >= lat);
        lat_cnt++;
      end else begin
        mem_done = ($urandom_range(0, 7) == 0);
        lat      = $urandom_range(0, 3);
        lat_cnt  = 0;
      end
      mem_rdata = $urandom;
      step();
      for (int i = 0; i < N; i++) if (ch_done[i]) ch_valid[i] = 1'b0;
    end

    ch_valid = '0;
    for (int n = 0; n < 8; n++) begin
      mem_done = mem_valid;
      step();
    end
    mem_done = 1'b0;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("final_idle",    64'(busy),         64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gelato_l1_cache_arbiter.md
Name: gelato_l1_cache_arbiter

Overview:
- Parametrised successor to the single-master L1 cache port.
- Shares one L1 cache port among NUM_CH requesters, e.g. per-warp I-fetch units or several load/store buffers.
- Arbitration is round-robin with exactly one outstanding cache transaction.
- Adds write support, which the single-master read-only port lacks.
- Sits between the requesters and the I-cache or D-cache slave.

Parameters:
NUM_CH, 4, number of requester channels; must be >= 2
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, read and write data width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
ch_valid  input  NUM_CH  per-channel request valid; held high until that channel's ch_done
ch_we  input  NUM_CH  per-channel write enable (1 = write, 0 = read)
ch_addr  input  NUM_CH*ADDR_WIDTH  per-channel address; channel i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_wdata  input  NUM_CH*DATA_WIDTH  per-channel write data, sliced the same way
ch_done  output  NUM_CH  one-cycle completion pulse to the granted channel
ch_rdata  output  DATA_WIDTH  read data, shared across channels; valid when any ch_done bit is 1
mem_valid  output  1  request valid towards the cache
mem_we  output  1  write enable towards the cache
mem_addr  output  ADDR_WIDTH  address towards the cache
mem_wdata  output  DATA_WIDTH  write data towards the cache
mem_done  input  1  cache completion pulse
mem_rdata  input  DATA_WIDTH  cache read data; valid only with mem_done
busy  output  1  high in BUSY and RESP states

Behaviour:
- Reset (asynchronous assert, synchronous release) forces:
  - state = IDLE, round-robin pointer rr_ptr = 0, grant index = 0
  - mem_valid, mem_we, mem_addr, mem_wdata = 0
  - ch_done, ch_rdata, busy = 0
- States:
  - IDLE: if any ch_valid is 1, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_CH. Latch the grant index, ch_we, ch_addr and ch_wdata of that channel into the mem_* registers. Set mem_valid = 1 and go to BUSY. If no ch_valid is set, stay in IDLE.
  - BUSY: mem_valid, mem_we, mem_addr and mem_wdata stay stable. Inputs that change on ch_* during BUSY are ignored. On mem_done = 1:
    - mem_valid clears
    - ch_rdata = mem_rdata if the request was a read; if it was a write, ch_rdata keeps its previous value
    - ch_done[grant] = 1
    - rr_ptr = (grant + 1) mod NUM_CH
    - go to RESP
  - RESP: ch_done is high for this one cycle only. No arbitration happens in this cycle, so the granted channel has time to drop ch_valid. Next state is IDLE with ch_done = 0.
- Latency:
  - ch_valid sampled high in cycle t gives mem_valid = 1 in cycle t+1.
  - mem_done in cycle u gives ch_done in cycle u+1.
  - The next grant is issued no earlier than u+2. Minimum issue-to-issue spacing is 3 cycles plus the cache latency.
- Only ch_done and ch_rdata are observable per completion. ch_rdata holds its value until the next read completion.
- mem_done in IDLE or RESP is ignored; it causes no state change and no ch_done.
- A requester that drops ch_valid before its grant is dropped silently. Once granted, the transaction completes regardless of ch_valid.
- Fairness: a continuously requesting channel waits for at most NUM_CH-1 other grants.
- rst_n asserted mid-transaction returns the block to the reset state immediately and discards the in-flight request. No ch_done is produced for it.

Test Plan:
- Single read: reset, then ch_valid=4'b0010, ch_addr[1]=0x1000; cache returns mem_done with mem_rdata=0xDEADBEEF three cycles after mem_valid -> mem_addr=0x1000 and mem_we=0 one cycle after the request; ch_done=4'b0010 and ch_rdata=0xDEADBEEF one cycle after mem_done; busy low two cycles after mem_done.
- Write: ch_valid=4'b0001, ch_we[0]=1, addr 0x20, wdata 0x55AA -> mem_we=1, mem_wdata=0x55AA; on mem_done, ch_done=4'b0001 and ch_rdata unchanged.
- Round-robin: all four channels request continuously with single-cycle cache latency -> grant order 0,1,2,3,0,1, each ch_done pulse exactly one cycle wide.
- Pointer wrap: rr_ptr=3 after serving channel 2, then requests on channels 0 and 2 only -> channel 0 granted first, then channel 2.
- Stray mem_done in IDLE and during the RESP cycle -> no ch_done and no state change; a requester that drops ch_valid before its grant -> never granted.
- Reset during BUSY: assert rst_n low while mem_valid=1 -> mem_valid, busy and ch_done = 0 immediately; after release, a fresh request from channel 0 is granted normally.
